// File: rtl/alu_master.sv
// rtl/alu_master.sv - instruction execution engine between instruction FIFO, register file and result FIFO
//
// Purpose: on alu_begin, pops instructions one at a time, reads two operands,
// computes a 32-bit result and pushes it to the result FIFO. Reports the end of
// a run on alu_done and a faulted run on alu_err.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   alu_begin             run request level from the slave
//   alu_done, alu_err     run finished / run ended in fault (held until alu_begin low)
//   i_empty, i_pop        instruction FIFO status / one-cycle pop request
//   i_rd_ack, i_rd_err    pop accepted (i_dout valid) / pop rejected
//   i_dout                popped instruction {ignored, opcode, addr A, addr B}
//   rAddr0, rAddr1        register file read addresses
//   rData0, rData1        operands, valid the cycle after the addresses register
//   r_push, r_din         one-cycle push request / result data held until ack/err
//   r_wr_ack, r_wr_err    push accepted / push rejected
//   result_cnt            results pushed since the last begin (wraps)

module alu_master #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_begin,
  output logic             alu_done,
  output logic             alu_err,
  input  logic             i_empty,
  output logic             i_pop,
  input  logic             i_rd_ack,
  input  logic             i_rd_err,
  input  logic [31:0]      i_dout,
  output logic [3:0]       rAddr0,
  output logic [3:0]       rAddr1,
  input  logic [31:0]      rData0,
  input  logic [31:0]      rData1,
  output logic             r_push,
  output logic [31:0]      r_din,
  input  logic             r_wr_ack,
  input  logic             r_wr_err,
  output logic [CNT_W-1:0] result_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, POP, WAIT_INST, READ_OPS, EXEC, PUSH, WAIT_PUSH, DONE, FAULT
  } state_t;

  state_t        state;
  state_t        decision;
  logic [11:0]   inst;
  logic [31:0]   opa;
  logic [31:0]   opb;
  logic [TW-1:0] tmo;
  logic [31:0]   exec_res;
  logic          exec_illegal;
  logic          tmo_expired;

  // Instruction bits above the opcode carry no meaning for this engine.
  logic unused_inst_bits;
  assign unused_inst_bits = ^i_dout[31:12];

  assign tmo_expired = (tmo == TW'(TIMEOUT - 1));

  // Where to go once an instruction has fully completed.
  always_comb begin
    decision = POP;
    if (!alu_begin) begin
      decision = IDLE;
    end else if (i_empty) begin
      decision = DONE;
    end
  end

  always_comb begin
    exec_res     = '0;
    exec_illegal = 1'b0;
    case (inst[11:8])
      4'h0: exec_res = '0;
      4'h1: exec_res = opa + opb;
      4'h2: exec_res = opa - opb;
      4'h3: exec_res = opa & opb;
      4'h4: exec_res = opa | opb;
      4'h5: exec_res = opa ^ opb;
      4'h6: exec_res = ~opa;
      4'h7: exec_res = opa << opb[4:0];
      4'h8: exec_res = opa >> opb[4:0];
      4'h9: exec_res = $signed(opa) >>> opb[4:0];
      4'hA: exec_res = opa * opb;
      default: exec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      alu_done   <= 1'b0;
      alu_err    <= 1'b0;
      i_pop      <= 1'b0;
      r_push     <= 1'b0;
      r_din      <= '0;
      rAddr0     <= '0;
      rAddr1     <= '0;
      result_cnt <= '0;
      inst       <= '0;
      opa        <= '0;
      opb        <= '0;
      tmo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (alu_begin) begin
            if (i_empty) begin
              state    <= DONE;
              alu_done <= 1'b1;
              alu_err  <= 1'b0;
            end else begin
              state      <= POP;
              i_pop      <= 1'b1;
              result_cnt <= '0;
            end
          end
        end

        POP: begin
          i_pop <= 1'b0;
          tmo   <= '0;
          state <= WAIT_INST;
        end

        WAIT_INST: begin
          if (i_rd_ack) begin
            inst   <= i_dout[11:0];
            rAddr0 <= i_dout[7:4];
            rAddr1 <= i_dout[3:0];
            state  <= READ_OPS;
          end else if (i_rd_err) begin
            state    <= DONE;
            alu_done <= 1'b1;
            alu_err  <= 1'b0;
          end else if (tmo_expired) begin
            state    <= FAULT;
            alu_done <= 1'b1;
            alu_err  <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        READ_OPS: begin
          opa   <= rData0;
          opb   <= rData1;
          state <= EXEC;
        end

        EXEC: begin
          if (exec_illegal) begin
            state    <= FAULT;
            alu_done <= 1'b1;
            alu_err  <= 1'b1;
          end else if (inst[11:8] == 4'h0) begin
            state    <= decision;
            i_pop    <= (decision == POP);
            alu_done <= (decision == DONE);
          end else begin
            r_din  <= exec_res;
            r_push <= 1'b1;
            state  <= PUSH;
          end
        end

        PUSH: begin
          r_push <= 1'b0;
          tmo    <= '0;
          state  <= WAIT_PUSH;
        end

        WAIT_PUSH: begin
          if (r_wr_ack) begin
            result_cnt <= result_cnt + CNT_W'(1);
            state      <= decision;
            i_pop      <= (decision == POP);
            alu_done   <= (decision == DONE);
          end else if (r_wr_err || tmo_expired) begin
            state    <= FAULT;
            alu_done <= 1'b1;
            alu_err  <= 1'b1;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        DONE, FAULT: begin
          if (!alu_begin) begin
            state    <= IDLE;
            alu_done <= 1'b0;
            alu_err  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_master.sv
// tb/tb_alu_master.sv - scoreboard testbench for alu_master with FIFO and register file models

module tb_alu_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_begin = 1'b0;
  logic        alu_done, alu_err;
  logic        i_empty = 1'b1;
  logic        i_pop;
  logic        i_rd_ack = 1'b0, i_rd_err = 1'b0;
  logic [31:0] i_dout = '0;
  logic [3:0]  rAddr0, rAddr1;
  logic [31:0] rData0, rData1;
  logic        r_push;
  logic [31:0] r_din;
  logic        r_wr_ack = 1'b0, r_wr_err = 1'b0;
  logic [7:0]  result_cnt;

  alu_master #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .alu_begin(alu_begin), .alu_done(alu_done), .alu_err(alu_err),
    .i_empty(i_empty), .i_pop(i_pop), .i_rd_ack(i_rd_ack), .i_rd_err(i_rd_err), .i_dout(i_dout),
    .rAddr0(rAddr0), .rAddr1(rAddr1), .rData0(rData0), .rData1(rData1),
    .r_push(r_push), .r_din(r_din), .r_wr_ack(r_wr_ack), .r_wr_err(r_wr_err),
    .result_cnt(result_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [16];
  logic [31:0] iq [$];
  logic [31:0] exp_q [$];
  bit  ipend = 0, wpend = 0;
  bit  stall_inst = 0, stall_push = 0, push_err = 0;
  int  pops = 0;
  bit  prev_strobe = 0;

  assign rData0 = regs[rAddr0];
  assign rData1 = regs[rAddr1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference semantics of one instruction, written from the opcode table.
  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    int sh;
    sh = int'(b % 32);
    case (op)
      4'h1: return a + b;
      4'h2: return a - b;
      4'h3: return a & b;
      4'h4: return a | b;
      4'h5: return a ^ b;
      4'h6: return ~a;
      4'h7: return a << sh;
      4'h8: return a >> sh;
      4'h9: begin
        wide = {{32{a[31]}}, a} >> sh;
        return wide[31:0];
      end
      4'hA: begin
        wide = 64'(a) * 64'(b);
        return wide[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  // Queues the program and the scoreboard entries; returns expected err and count.
  task automatic load(input logic [31:0] prog [$], output bit exp_err, output int exp_cnt);
    logic [3:0] op;
    exp_err = 0;
    exp_cnt = 0;
    foreach (prog[k]) begin
      iq.push_back(prog[k]);
      if (!exp_err) begin
        op = prog[k][11:8];
        if (op > 4'hA) exp_err = 1;
        else if (op != 4'h0) begin
          exp_q.push_back(ref_op(op, regs[prog[k][7:4]], regs[prog[k][3:0]]));
          exp_cnt++;
        end
      end
    end
    i_empty = (iq.size() == 0);
  endtask

  task automatic run(input string name, input bit exp_err, input int exp_cnt);
    bit seen = 0;
    alu_begin = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (alu_done) begin
        seen = 1;
        break;
      end
    end
    chk({name, "_done"}, 32'(seen), 32'd1);
    chk({name, "_err"}, 32'(alu_err), 32'(exp_err));
    chk({name, "_cnt"}, 32'(result_cnt), 32'(exp_cnt & 8'hFF));
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    alu_begin = 1'b0;
    @(negedge clk);
    chk({name, "_idle"}, {29'd0, alu_done, alu_err, i_pop | r_push}, 32'd0);
  endtask

  // Instruction FIFO: answers a pop during the cycle after i_pop.
  always @(negedge clk) begin
    if (reset) begin
      i_rd_ack = 0; i_rd_err = 0; ipend = 0;
    end else begin
      i_rd_ack = 0; i_rd_err = 0;
      if (ipend && !stall_inst) begin
        if (iq.size() > 0) begin
          i_dout = iq.pop_front();
          i_rd_ack = 1;
        end else begin
          i_rd_err = 1;
        end
      end
      ipend = i_pop;
      if (i_pop) pops++;
      i_empty = (iq.size() == 0);
    end
  end

  // Result FIFO: answers a push during the cycle after r_push.
  always @(negedge clk) begin
    if (reset) begin
      r_wr_ack = 0; r_wr_err = 0; wpend = 0;
    end else begin
      r_wr_ack = 0; r_wr_err = 0;
      if (wpend && !stall_push) begin
        if (push_err) r_wr_err = 1;
        else r_wr_ack = 1;
      end
      wpend = r_push;
    end
  end

  // Scoreboard monitor and strobe protocol checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (r_push) begin
        if (exp_q.size() == 0) chk("unexpected_push", r_din, 32'hxxxx_xxxx);
        else chk("push_data", r_din, exp_q.pop_front());
      end
      if (i_pop || r_push) begin
        chk("strobe_proto", {30'd0, i_pop & r_push, prev_strobe}, 32'd0);
      end
      prev_strobe = i_pop | r_push;
    end else begin
      prev_strobe = 0;
    end
  end

  initial begin
    logic [31:0] prog [$];
    bit e;
    int c;
    bit seen;

    foreach (regs[k]) regs[k] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", {26'd0, alu_done, alu_err, i_pop, r_push, 2'b00}, 32'd0);
    chk("rst_din", r_din, 32'd0);
    chk("rst_cnt", {16'd0, rAddr0, rAddr1, result_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single ADD
    regs[1] = 5; regs[2] = 3;
    prog = {32'h112};
    load(prog, e, c);
    chk("add_model", exp_q[0], 32'd8);
    run("add", e, c);

    // Shifts and wrapping subtract
    regs[3] = 32'h8000_0000; regs[4] = 4;
    prog = {32'h934, 32'h834, 32'h243};
    load(prog, e, c);
    run("shifts", e, c);

    // Illegal opcode
    prog = {32'h0B00};
    load(prog, e, c);
    run("illegal", 1, 0);

    // Push rejected
    push_err = 1;
    prog = {32'h112};
    load(prog, e, c);
    run("push_err", 1, 0);
    push_err = 0;

    // Instruction pop never answered
    stall_inst = 1;
    prog = {32'h112};
    load(prog, e, c);
    exp_q.delete();
    run("inst_tmo", 1, 0);
    stall_inst = 0;
    iq.delete(); ipend = 0; i_empty = 1;

    // Empty run
    c = pops;
    run("empty", 0, 0);
    chk("empty_nopop", 32'(pops), 32'(c));

    // Random programs
    for (int t = 0; t < 25; t++) begin
      foreach (regs[k]) regs[k] = $urandom;
      prog.delete();
      for (int n = 0; n < int'($urandom_range(1, 6)); n++)
        prog.push_back({$urandom_range(0, 32'hFFFFF), 4'($urandom_range(0, 10)), 8'($urandom)});
      load(prog, e, c);
      run($sformatf("rand%0d", t), e, c);
    end

    // Reset while waiting on a push acknowledge
    stall_push = 1;
    regs[1] = 7; regs[2] = 9;
    prog = {32'h112};
    load(prog, e, c);
    alu_begin = 1'b1;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (r_push) begin
        seen = 1;
        break;
      end
    end
    chk("rstmid_push_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_outs", {28'd0, alu_done, alu_err, i_pop, r_push}, 32'd0);
    chk("rstmid_din", r_din, 32'd0);
    chk("rstmid_cnt", {16'd0, rAddr0, rAddr1, result_cnt}, 32'd0);
    alu_begin = 1'b0;
    stall_push = 0;
    iq.delete(); exp_q.delete(); i_empty = 1;
    @(negedge clk);
    reset = 1'b0;
    c = pops;
    repeat (5) @(negedge clk);
    chk("rstmid_stay_idle", {29'd0, alu_done, i_pop, r_push}, 32'd0);
    chk("rstmid_nopop", 32'(pops), 32'(c));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_master.md
Name: alu_master

Overview:
- Execution engine downstream of the ALU slave.
- On alu_begin it drains the instruction FIFO one instruction at a time, reads two operands from the register file, and computes a 32-bit result. Each result is pushed into the result FIFO, which the slave pops.
- Signals completion to the slave through alu_done, and flags faults through alu_err.

Parameters:
- TIMEOUT, 16, max cycles to wait for a FIFO ack/err before faulting.
- CNT_W, 8, width of result counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_begin  in  1  level from slave; high = run.
- alu_done  out  1  run finished (normal or fault); held until alu_begin low.
- alu_err  out  1  run ended in FAULT; valid while alu_done high.
- i_empty  in  1  instruction FIFO empty.
- i_pop  out  1  one-cycle pop request to instruction FIFO.
- i_rd_ack  in  1  pop accepted; i_dout valid this cycle.
- i_rd_err  in  1  pop rejected (FIFO empty).
- i_dout  in  32  popped instruction.
- rAddr0  out  4  register file read address A.
- rAddr1  out  4  register file read address B.
- rData0  in  32  operand A; valid the cycle after rAddr0 is registered.
- rData1  in  32  operand B; same timing as rData0.
- r_push  out  1  one-cycle push request to result FIFO.
- r_din  out  32  result data; held stable until ack/err.
- r_wr_ack  in  1  push accepted.
- r_wr_err  in  1  push rejected (FIFO full).
- result_cnt  out  CNT_W  results pushed since last begin; wraps.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal instruction, operand, result and timeout registers 0. Reset mid-run aborts immediately; no pending handshake is resumed.
- Instruction format:
  - [11:8] opcode, [7:4] operand A address, [3:0] operand B address; [31:12] ignored.
  - Opcodes: 0 NOP (no push); 1 ADD A+B mod 2^32; 2 SUB A-B mod 2^32; 3 AND; 4 OR; 5 XOR; 6 NOT A; 7 LSL A by B[4:0]; 8 LSR A by B[4:0] (zero fill); 9 ASR A by B[4:0] (sign fill); A MUL, low 32 bits of the unsigned product.
  - Opcodes B-F are illegal.
- FSM states: IDLE, POP, WAIT_INST, READ_OPS, EXEC, PUSH, WAIT_PUSH, DONE, FAULT.
- IDLE:
  - alu_begin=1 and i_empty=1: go to DONE (empty run, alu_err=0).
  - alu_begin=1 and i_empty=0: clear result_cnt, go to POP.
- POP: i_pop=1 for exactly one cycle, then WAIT_INST; clear timeout counter.
- WAIT_INST:
  - i_rd_ack: latch i_dout, register rAddr0/rAddr1 from the instruction, go to READ_OPS.
  - i_rd_err: go to DONE (FIFO drained).
  - Neither for TIMEOUT cycles: go to FAULT.
  - ack and err in the same cycle: ack wins.
- READ_OPS: one-cycle wait; latch rData0/rData1; go to EXEC.
- EXEC:
  - Illegal opcode: go to FAULT; no push.
  - NOP: go to the next-instruction decision.
  - Otherwise: register the result into r_din, go to PUSH.
- PUSH: r_push=1 for exactly one cycle, then WAIT_PUSH; clear timeout counter.
- WAIT_PUSH:
  - r_wr_ack: result_cnt+1, go to the next-instruction decision.
  - r_wr_err: go to FAULT.
  - Timeout: go to FAULT.
  - ack and err in the same cycle: ack wins.
- Next-instruction decision, evaluated in the same cycle as the transition:
  - alu_begin=0: go to IDLE with no alu_done (abort at instruction boundary).
  - i_empty=1: go to DONE.
  - Otherwise: go to POP.
- DONE: alu_done=1, alu_err=0; when alu_begin=0, go to IDLE next cycle (alu_done drops then).
- FAULT: alu_done=1, alu_err=1; when alu_begin=0, go to IDLE.
- alu_begin deasserting in any state other than the decision point, DONE or FAULT is ignored until the current instruction completes.
- r_din, rAddr0 and rAddr1 keep their last values outside active states.
- i_pop and r_push are never high simultaneously and never high two consecutive cycles.
- Per-instruction latency, assuming one-cycle acks: POP, WAIT_INST, READ_OPS, EXEC, PUSH, WAIT_PUSH = 6 cycles.

Test Plan:
- Reg1=5, reg2=3; FIFO holds 0x112 (ADD), alu_begin=1 -> one r_push with r_din=0x00000008; alu_done=1, alu_err=0, result_cnt=1.
- Regs A=0x80000000, B=4; FIFO holds ASR, LSR, SUB with B>A -> results 0xF8000000, 0x08000000, wrapped difference; result_cnt=3.
- Instruction 0x0B00 (illegal) -> no r_push; alu_done=1, alu_err=1; alu_begin=0 -> IDLE next cycle, outputs 0.
- r_wr_err on first push -> FAULT. Separately, withhold i_rd_ack/err for 16 cycles -> FAULT.
- alu_begin=1 with i_empty=1 -> DONE; no i_pop; result_cnt=0.
- Reset asserted during WAIT_PUSH -> all outputs 0 asynchronously; after release with alu_begin=0, stays IDLE.
